video_timing_gen: RTL and testbench

Raster timing and test-pattern source for the DVI/HDMI output path. It generates horizontal and vertical sync, the video-enable strobe and 8-bit RGB pixel data for one pixel clock domain. Its outputs drive the three TMDS channel encoders directly:
- `o_red`, `o_green`, `o_blue` go to the encoder data inputs.
- `{o_vs, o_hs}` goes to the blue-channel control input.
- `o_de` goes to every encoder's video-enable input.

---
 rtl/video_timing_gen.sv | 148 ++++++++++++++
 tb/tb_video_timing_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern source for one pixel clock domain.
// Outputs are the registered decode of the (h,v) counters, one cycle behind them.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_pattern,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_frame_start,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] BAR_LOAD = 12'(H_ACTIVE / 8 - 1);

    localparam logic [1:0] PAT_BARS    = 2'b00;
    localparam logic [1:0] PAT_GRAD    = 2'b01;
    localparam logic [1:0] PAT_CHECKER = 2'b10;
    localparam logic [1:0] PAT_BLACK   = 2'b11;

    logic [11:0] h;
    logic [11:0] v;
    logic [11:0] bar_cnt;
    logic [2:0]  bar_idx;
    logic [1:0]  pat_q;

    logic        h_last;
    logic        v_last;
    logic        at_origin;
    logic        de_c;
    logic        hs_act;
    logic        vs_act;
    logic [1:0]  pat_eff;
    logic [23:0] rgb_c;

    assign h_last    = (h == H_LAST);
    assign v_last    = (v == V_LAST);
    assign at_origin = (h == 12'd0) && (v == 12'd0);
    assign de_c      = (h < H_ACT) && (v < V_ACT);
    assign hs_act    = (h >= HS_START) && (h < HS_END);
    assign vs_act    = (v >= VS_START) && (v < VS_END);
    // The latch and its first use share the origin edge, so bypass the register there.
    assign pat_eff   = at_origin ? i_pattern : pat_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h       <= '0;
            v       <= '0;
            bar_cnt <= BAR_LOAD;
            bar_idx <= '0;
            pat_q   <= PAT_BLACK;
        end else begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? 12'd0 : v + 12'd1;
            end else begin
                h <= h + 12'd1;
            end

            if (at_origin) begin
                pat_q <= i_pattern;
            end

            if (h_last) begin
                bar_cnt <= BAR_LOAD;
                bar_idx <= '0;
            end else if (bar_cnt == 12'd0) begin
                bar_cnt <= BAR_LOAD;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt - 12'd1;
            end
        end
    end

    always_comb begin
        rgb_c = '0;
        case (pat_eff)
            PAT_BARS: begin
                case (bar_idx)
                    3'd0:    rgb_c = 24'hFFFFFF;
                    3'd1:    rgb_c = 24'hFFFF00;
                    3'd2:    rgb_c = 24'h00FFFF;
                    3'd3:    rgb_c = 24'h00FF00;
                    3'd4:    rgb_c = 24'hFF00FF;
                    3'd5:    rgb_c = 24'hFF0000;
                    3'd6:    rgb_c = 24'h0000FF;
                    default: rgb_c = 24'h000000;
                endcase
            end
            PAT_GRAD:    rgb_c = {3{h[9:2]}};
            PAT_CHECKER: rgb_c = (h[5] ^ v[5]) ? 24'hFFFFFF : 24'h000000;
            default:     rgb_c = 24'h000000;
        endcase
        if (!de_c) begin
            rgb_c = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hs          <= ~HS_POL;
            o_vs          <= ~VS_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
            o_red         <= '0;
            o_green       <= '0;
            o_blue        <= '0;
        end else begin
            o_hs          <= hs_act ? HS_POL : ~HS_POL;
            o_vs          <= vs_act ? VS_POL : ~VS_POL;
            o_de          <= de_c;
            o_x           <= h;
            o_y           <= v;
            o_frame_start <= at_origin;
            {o_red, o_green, o_blue} <= rgb_c;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced raster (80x56 total, 64x48 active).
// Bar width is 8, h-sync spans x 68..75, v-sync spans y 50..52, frame is 4480 cycles.
module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [1:0]  i_pattern;
    logic        o_hs, o_vs, o_de, o_frame_start;
    logic [11:0] o_x, o_y;
    logic [7:0]  o_red, o_green, o_blue;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c0    = 0;
    int de_cnt, hs_cnt, vs_cnt, blank_bad;
    int vs_x, vs_y;
    logic vs_prev;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(3), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_pattern(i_pattern),
        .o_hs(o_hs),
        .o_vs(o_vs),
        .o_de(o_de),
        .o_x(o_x),
        .o_y(o_y),
        .o_frame_start(o_frame_start),
        .o_red(o_red),
        .o_green(o_green),
        .o_blue(o_blue)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, o_red, o_green, o_blue};
    endfunction

    task automatic clear_stats();
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; blank_bad = 0;
        vs_x = -1; vs_y = -1; vs_prev = 1'b1;
    endtask

    // Tallies the pixel currently shown, then advances one clock.
    task automatic tick();
        if (o_de) de_cnt++;
        if (!o_hs) hs_cnt++;
        if (!o_vs) begin
            vs_cnt++;
            if (vs_prev && vs_x < 0) begin
                vs_x = int'(o_x);
                vs_y = int'(o_y);
            end
        end
        vs_prev = o_vs;
        if (!o_de && rgb() != 32'd0) blank_bad++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_xy(input int x, input int y);
        bit found = 1'b0;
        for (int n = 0; n < 10000 && !found; n++) begin
            if (int'(o_x) == x && int'(o_y) == y) found = 1'b1;
            else tick();
        end
        if (!found) begin
            total++;
            bad++;
            $error("FAIL wait_%0d_%0d observed=timeout expected=reached", x, y);
        end
    endtask

    initial begin
        i_rst     = 1'b1;
        i_pattern = 2'b00;
        clear_stats();
        repeat (3) tick();
        chk("rst_hs", o_hs, 1);
        chk("rst_vs", o_vs, 1);
        chk("rst_de", o_de, 0);
        chk("rst_rgb", rgb(), 0);
        chk("rst_fs", o_frame_start, 0);
        chk("rst_x", o_x, 0);

        i_rst = 1'b0;
        tick();
        chk("rel_fs", o_frame_start, 1);
        chk("rel_x", o_x, 0);
        chk("rel_y", o_y, 0);
        chk("rel_de", o_de, 1);
        chk("rel_rgb", rgb(), 32'hFFFFFF);
        clear_stats();
        c0 = cyc;

        for (int i = 1; i < 80; i++) begin
            tick();
            if (i == 7)  chk("bar0_end", rgb(), 32'hFFFFFF);
            if (i == 8)  chk("bar1_start", rgb(), 32'hFFFF00);
            if (i == 47) chk("bar5_end", rgb(), 32'hFF0000);
            if (i == 48) chk("bar6_start", rgb(), 32'h0000FF);
            if (i == 55) chk("bar6_end", rgb(), 32'h0000FF);
            if (i == 56) chk("bar7_start", rgb(), 32'h000000);
            if (i == 63) chk("last_active_de", o_de, 1);
            if (i == 64) chk("first_blank_de", o_de, 0);
            if (i == 64) chk("first_blank_rgb", rgb(), 0);
            if (i == 67) chk("hs_before", o_hs, 1);
            if (i == 68) chk("hs_first", o_hs, 0);
            if (i == 68) chk("hs_first_x", o_x, 68);
            if (i == 75) chk("hs_last", o_hs, 0);
            if (i == 76) chk("hs_after", o_hs, 1);
        end
        chk("line_de_cnt", de_cnt, 64);
        chk("line_hs_cnt", hs_cnt, 8);
        tick();
        chk("line_wrap_x", o_x, 0);
        chk("line_wrap_y", o_y, 1);
        chk("line_period", cyc - c0, 80);

        wait_xy(10, 20);
        i_pattern = 2'b10;
        wait_xy(8, 30);
        chk("bars_hold", rgb(), 32'hFFFF00);

        wait_xy(0, 0);
        chk("frame_len", cyc - c0, 4480);
        chk("frame_fs", o_frame_start, 1);
        chk("frame_de_cnt", de_cnt, 3072);
        chk("frame_hs_cnt", hs_cnt, 448);
        chk("frame_vs_cnt", vs_cnt, 240);
        chk("vs_start_x", vs_x, 0);
        chk("vs_start_y", vs_y, 50);
        chk("blank_rgb", blank_bad, 0);
        chk("chk_0_0", rgb(), 32'h000000);
        i_pattern = 2'b01;
        wait_xy(32, 0);
        chk("chk_32_0", rgb(), 32'hFFFFFF);
        wait_xy(33, 31);
        chk("chk_33_31", rgb(), 32'hFFFFFF);
        wait_xy(32, 32);
        chk("chk_32_32", rgb(), 32'h000000);

        wait_xy(0, 0);
        wait_xy(20, 5);
        chk("grad_20", rgb(), 32'h050505);
        wait_xy(63, 1);
        chk("grad_63", rgb(), 32'h0F0F0F);

        wait_xy(5, 30);
        i_rst     = 1'b1;
        i_pattern = 2'b00;
        tick();
        chk("mr_de", o_de, 0);
        chk("mr_hs", o_hs, 1);
        chk("mr_vs", o_vs, 1);
        chk("mr_x", o_x, 0);
        chk("mr_y", o_y, 0);
        chk("mr_rgb", rgb(), 0);
        chk("mr_fs", o_frame_start, 0);
        i_rst = 1'b0;
        tick();
        chk("mr_rel_fs", o_frame_start, 1);
        chk("mr_rel_xy", {o_y, o_x}, 0);
        chk("mr_rel_rgb", rgb(), 32'hFFFFFF);
        tick();
        chk("mr_next_x", o_x, 1);
        chk("mr_next_fs", o_frame_start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
